// File: rtl/mem_ctrl.sv
// mem_ctrl: single-outstanding CPU-to-RAM controller with switch/LED MMIO
module mem_ctrl #(
  parameter int data_width = 16,
  parameter int addr_width = 8,
  parameter logic [addr_width:0] sw_addr = 9'h140,
  parameter logic [addr_width:0] led_addr = 9'h100
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [addr_width:0]     req_addr,
  input  logic [data_width-1:0]   req_wdata,
  output logic                    rsp_valid,
  output logic [data_width-1:0]   rsp_rdata,
  output logic [addr_width-1:0]   ram_read_address,
  output logic [addr_width-1:0]   ram_write_address,
  output logic                    ram_write,
  output logic [data_width-1:0]   ram_din,
  input  logic [data_width-1:0]   ram_dout,
  input  logic [7:0]              sw,
  output logic [7:0]              led
);
  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, EXEC, RESP} state_t;
  state_t                r_state;
  logic [addr_width:0]   r_lat_addr;
  logic [data_width-1:0] r_lat_wdata;
  logic                  r_lat_write;
  logic [data_width-1:0] r_rdata;
  logic [7:0]            r_led;
  logic                  w_accept;
  assign w_accept          = req_valid & (r_state == IDLE);
  assign req_ready         = r_state == IDLE;
  assign rsp_valid         = r_state == RESP;
  assign rsp_rdata         = r_rdata;
  assign led               = r_led;
  assign ram_read_address  = r_lat_addr[addr_width-1:0];
  assign ram_write_address = r_lat_addr[addr_width-1:0];
  assign ram_din           = r_lat_wdata;
  assign ram_write         = (r_state == EXEC) & r_lat_write & ~r_lat_addr[addr_width] & ~reset;
  // request sequencing, MMIO side effects and response data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_lat_addr  <= '0;
      r_lat_wdata <= '0;
      r_lat_write <= 1'b0;
      r_rdata     <= '0;
      r_led       <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_lat_addr  <= req_addr;
          r_lat_wdata <= req_wdata;
          r_lat_write <= req_write;
          r_state     <= (~req_write & ~req_addr[addr_width]) ? RD_ISSUE : EXEC;
        end
        RD_ISSUE: r_state <= RD_WAIT;
        RD_WAIT: begin
          r_rdata <= ram_dout;
          r_state <= RESP;
        end
        EXEC: begin
          if (r_lat_write && r_lat_addr == led_addr) r_led <= r_lat_wdata[7:0];
          if (!r_lat_write) r_rdata <= (r_lat_addr == sw_addr) ? {{(data_width-8){1'b0}}, sw} : '0;
          r_state <= RESP;
        end
        RESP: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized self-checking bench for mem_ctrl against a transaction-level model
module tb_mem_ctrl;
  logic        clk = 0;
  logic        reset = 1;
  logic        req_valid = 0, req_write = 0;
  logic [8:0]  req_addr = 0;
  logic [15:0] req_wdata = 0;
  logic        req_ready, rsp_valid, ram_write;
  logic [15:0] rsp_rdata, ram_din, ram_dout;
  logic [7:0]  ram_read_address, ram_write_address, led;
  logic [7:0]  sw = 0;
  logic [15:0] ram [256];
  logic [15:0] ref_mem [256];
  logic [7:0]  ref_led = 0;
  logic [15:0] last_rd = 0;
  int          n_tests = 0, n_fail = 0, cyc = 0, wr_cnt = 0;
  logic [7:0]  wr_addr = 0;
  int          acc_q[$];

  mem_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_read_address(ram_read_address), .ram_write_address(ram_write_address),
    .ram_write(ram_write), .ram_din(ram_din), .ram_dout(ram_dout),
    .sw(sw), .led(led)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_write) ram[ram_write_address] <= ram_din;
    ram_dout <= ram[ram_read_address];
  end

  always @(posedge clk) begin
    cyc++;
    if (!reset && req_valid && req_ready) acc_q.push_back(cyc);
    if (ram_write) begin
      wr_cnt++;
      wr_addr = ram_write_address;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [8:0] a);
    if (!a[8]) return ref_mem[a[7:0]];
    if (a == 9'h140) return {8'h00, sw};
    return 16'h0000;
  endfunction

  task automatic model_write(input logic [8:0] a, input logic [15:0] d);
    if (!a[8]) ref_mem[a[7:0]] = d;
    else if (a == 9'h100) ref_led = d[7:0];
  endtask

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = n < 20;
    check("ready_timeout", {31'b0, ok}, 1);
  endtask

  task automatic txn(input logic w, input logic [8:0] a, input logic [15:0] d);
    int n, w0;
    bit ok;
    logic [15:0] er;
    @(negedge clk);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
    wait_ready(ok);
    w0 = wr_cnt;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    n = 1;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (w) model_write(a, d);
    else begin
      er = model_read(a);
      last_rd = er;
    end
    check(w ? "store_latency" : "load_latency", n - 1, (!w && !a[8]) ? 2 : 1);
    check(w ? "store_rdata_hold" : "load_rdata", {16'b0, rsp_rdata}, {16'b0, last_rd});
    check("led", {24'b0, led}, {24'b0, ref_led});
    check("ram_write_count", wr_cnt - w0, (w && !a[8]) ? 1 : 0);
    if (w && !a[8]) check("ram_write_addr", {24'b0, wr_addr}, {24'b0, a[7:0]});
    @(negedge clk);
    check("rsp_single_pulse", {31'b0, rsp_valid}, 0);
  endtask

  task automatic abort_check(input string tag);
    @(negedge clk);
    reset = 0;
    ref_led = 0;
    last_rd = 0;
    check({tag, "_ready"}, {31'b0, req_ready}, 1);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_no_rsp"}, {31'b0, rsp_valid}, 0);
      @(negedge clk);
    end
    check({tag, "_led"}, {24'b0, led}, 0);
    check({tag, "_rdata"}, {16'b0, rsp_rdata}, 0);
  endtask

  initial begin
    logic [8:0]  a;
    logic [15:0] d;
    int          w0, got;
    bit          ok;
    for (int i = 0; i < 256; i++) ref_mem[i] = 0;
    for (int i = 0; i < 256; i++) ram[i] = 0;
    req_valid = 1;
    @(negedge clk);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    check("rst_led", {24'b0, led}, 0);
    check("rst_ram_write", {31'b0, ram_write}, 0);
    @(negedge clk);
    req_valid = 0;
    reset = 0;
    @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 1);
    check("rst_rdata", {16'b0, rsp_rdata}, 0);
    for (int i = 0; i < 3; i++) begin
      check("rst_no_rsp", {31'b0, rsp_valid}, 0);
      @(negedge clk);
    end

    txn(1, 9'h005, 16'hBEEF);
    txn(0, 9'h005, 16'h0000);
    sw = 8'hA5;
    txn(0, 9'h140, 16'h0000);
    txn(1, 9'h100, 16'h123C);
    txn(0, 9'h1FF, 16'h0000);
    txn(1, 9'h1FF, 16'h7777);
    txn(1, 9'h140, 16'h5555);
    txn(0, 9'h100, 16'h0000);
    for (int i = 0; i < 16; i++) txn(1, 9'(i), 16'($urandom));

    acc_q.delete();
    got = 0;
    @(negedge clk);
    req_valid = 1; req_write = 0; req_addr = 9'h001;
    for (int k = 1; k <= 3; k++) begin
      int n = 0;
      while (!rsp_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("b2b_timeout", {31'b0, n < 20}, 1);
      if (rsp_valid) got++;
      check("b2b_rdata", {16'b0, rsp_rdata}, {16'b0, ref_mem[k]});
      if (k == 3) req_valid = 0;
      req_addr = 9'(k + 1);
      @(negedge clk);
    end
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) got++;
      @(negedge clk);
    end
    last_rd = ref_mem[3];
    check("b2b_pulses", got, 3);
    check("b2b_accepts", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      check("b2b_space1", acc_q[1] - acc_q[0], 4);
      check("b2b_space2", acc_q[2] - acc_q[1], 4);
    end

    @(negedge clk);
    req_valid = 1; req_write = 0; req_addr = 9'h007;
    wait_ready(ok);
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    reset = 1;
    abort_check("abort_load");

    @(negedge clk);
    req_valid = 1; req_write = 1; req_addr = 9'h009; req_wdata = ~ref_mem[9];
    wait_ready(ok);
    w0 = wr_cnt;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    reset = 1;
    abort_check("abort_store");
    check("abort_store_no_write", wr_cnt - w0, 0);
    txn(0, 9'h009, 16'h0000);

    for (int i = 0; i < 60; i++) begin
      int sel = $urandom_range(0, 5);
      a = (sel < 3) ? 9'($urandom_range(0, 15)) : (sel == 3) ? 9'h140 : (sel == 4) ? 9'h100 : {1'b1, 8'($urandom)};
      d = 16'($urandom);
      sw = 8'($urandom);
      txn(1'($urandom), a, d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
